// File: rtl/fpu_sched_pkg.sv
// Shared opcodes, word width and scheduler state encoding for fpu_sched.
// The FPU_TIMEOUT_EN build also lets ADDF/SUBF/RECF through to the fpu.
package fpu_sched_pkg;

  localparam int WORD = 16;
  localparam int OPW  = 5;

  localparam logic [OPW-1:0] OPADDF = 5'h11;
  localparam logic [OPW-1:0] OPFTOI = 5'h12;
  localparam logic [OPW-1:0] OPITOF = 5'h13;
  localparam logic [OPW-1:0] OPMULF = 5'h14;
  localparam logic [OPW-1:0] OPSUBF = 5'h15;
  localparam logic [OPW-1:0] OPRECF = 5'h16;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP,
    REJECT,
    ABORT
  } sched_state_e;

  // ADDF/SUBF/RECF never complete on their own, so they are only safe to launch when a timeout exists.
  function automatic logic op_launchable(input logic [OPW-1:0] op, input logic allow_ext);
    logic ok;
    ok = (op == OPITOF) || (op == OPFTOI) || (op == OPMULF);
    if (allow_ext)
      ok = ok || (op == OPADDF) || (op == OPSUBF) || (op == OPRECF);
    return ok;
  endfunction

endpackage

// File: rtl/fpu_sched_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or after ptr_i, with wrap.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            any_o,
  output logic [IW-1:0]   sel_o,
  output logic [NREQ-1:0] grant_o
);

  logic [IW-1:0] idx;

  // Walk offsets from the far end down so the nearest request to ptr_i is written last and wins.
  always_comb begin
    any_o = 1'b0;
    sel_o = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_i) + k) % NREQ);
      if (req_i[idx]) begin
        any_o = 1'b1;
        sel_o = idx;
      end
    end
    grant_o = any_o ? (NREQ'(1) << sel_o) : '0;
  end

endmodule

// File: rtl/fpu_sched.sv
// fpu_sched: round-robin front end sharing one multi-cycle fpu among NREQ requesters.
// Optional build macro FPU_TIMEOUT_EN adds a WAIT watchdog that aborts a hung op.
module fpu_sched
  import fpu_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [OPW*NREQ-1:0]    req_instr,
  input  logic [WORD*NREQ-1:0]   req_op1,
  input  logic [WORD*NREQ-1:0]   req_op2,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [WORD-1:0]        rsp_result,
  output logic                   rsp_err,
  output logic                   fpu_en,
  output logic [OPW-1:0]         fpu_instr,
  output logic [WORD-1:0]        fpu_op1,
  output logic [WORD-1:0]        fpu_op2,
  input  logic [WORD-1:0]        fpu_result,
  input  logic                   fpu_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fpu_sched: NREQ must be 2..8 and TIMEOUT at least 1");
  end

`ifdef FPU_TIMEOUT_EN
  localparam int   CW        = $clog2(TIMEOUT + 1);
  localparam logic ALLOW_EXT = 1'b1;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  localparam logic ALLOW_EXT = 1'b0;
`endif

  sched_state_e     state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [OPW-1:0]   instr_q, instr_d;
  logic [WORD-1:0]  op1_q, op1_d;
  logic [WORD-1:0]  op2_q, op2_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WORD-1:0]  rsp_result_q, rsp_result_d;
  logic             rsp_err_q, rsp_err_d;

  logic             pick_any;
  logic [IW-1:0]    pick_sel;
  logic [NREQ-1:0]  pick_grant;
  logic [OPW-1:0]   sel_instr;
  logic [WORD-1:0]  sel_op1, sel_op2;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .any_o   (pick_any),
    .sel_o   (pick_sel),
    .grant_o (pick_grant)
  );

  always_comb begin
    sel_instr = '0;
    sel_op1   = '0;
    sel_op2   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_sel == IW'(i)) begin
        sel_instr = req_instr[OPW*i +: OPW];
        sel_op1   = req_op1[WORD*i +: WORD];
        sel_op2   = req_op2[WORD*i +: WORD];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      instr_q      <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      gnt_q        <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
`ifdef FPU_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      instr_q      <= instr_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      gnt_q        <= gnt_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
`ifdef FPU_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // fpu_en and rsp_valid decode straight from state so an async reset clears them at once.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    instr_d      = instr_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    gnt_d        = '0;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    fpu_en       = 1'b0;
    rsp_valid    = '0;
`ifdef FPU_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_grant;
          owner_d = pick_sel;
          instr_d = sel_instr;
          op1_d   = sel_op1;
          op2_d   = sel_op2;
          if (op_launchable(sel_instr, ALLOW_EXT)) begin
            state_d = LAUNCH;
          end else begin
            state_d      = REJECT;
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
          end
        end
      end

      // done here still belongs to the previous op, so it is not looked at.
      LAUNCH: begin
        fpu_en  = 1'b1;
        state_d = WAIT;
`ifdef FPU_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      WAIT: begin
        fpu_en = !fpu_done;
        if (fpu_done) begin
          rsp_result_d = fpu_result;
          rsp_err_d    = 1'b0;
          state_d      = RESP;
        end
`ifdef FPU_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(TIMEOUT)) begin
            rsp_result_d = '1;
            rsp_err_d    = 1'b1;
            state_d      = ABORT;
          end
        end
`endif
      end

      RESP, REJECT, ABORT: begin
        rsp_valid = NREQ'(1) << owner_q;
        rr_ptr_d  = IW'((int'(owner_q) + 1) % NREQ);
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign gnt        = gnt_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign fpu_instr  = instr_q;
  assign fpu_op1    = op1_q;
  assign fpu_op2    = op2_q;

endmodule
